// File: rtl/hanoi_solver.sv
// ----------------------------------------------------------------------------
// hanoi_solver
//   Sequencer that drives the from/to move inputs of a towers-of-Hanoi puzzle
//   model. After start, issues the optimal 2^N-1 move sequence (one move per
//   non-stalled clock) that transfers the tower from peg A to peg B. Whenever
//   no real move is presented, from==to==A so the puzzle model holds.
//
//   Peg encoding: A=2'd0, B=2'd1, C=2'd2 (2'd3 never driven).
//
// Parameters
//   N   number of discs, 1..16
//   KW  width of move_count; 2^N-1 must fit in KW bits
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   asynchronous, active-high; returns to IDLE
//   start       in   level, sampled in IDLE only
//   stall       in   level, one registered no-op per stalled cycle
//   from/to     out  source/destination peg of the current move
//   move_valid  out  from/to hold a real move this cycle
//   busy        out  sequence in progress
//   done        out  all 2^N-1 moves issued (terminal until reset)
//   move_count  out  number of moves issued so far
//   err         out  only with HANOI_SOLVER_CHECK_EN: sticky shadow-count error
//
// Optional feature: define HANOI_SOLVER_CHECK_EN to add shadow disc counters
// per peg and the err output.
// ----------------------------------------------------------------------------
module hanoi_solver #(
    parameter int N  = 5,
    parameter int KW = N
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    output logic [1:0]    from,
    output logic [1:0]    to,
    output logic          move_valid,
    output logic          busy,
    output logic          done,
    output logic [KW-1:0] move_count
`ifdef HANOI_SOLVER_CHECK_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FINISHED} state_t;

    localparam logic [1:0]  PEG_A = 2'd0;
    // k runs 1..2^N inclusive, hence one bit wider than move_count.
    localparam logic [KW:0] LAST_K = (KW+1)'((1 << N) - 1);

    state_t        r_state, w_state_next;
    logic [KW:0]   r_k, w_k_next;
    logic [1:0]    r_from, r_to, w_from_next, w_to_next;
    logic          r_valid, w_valid_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic [KW-1:0] r_count, w_count_next;
    logic          w_issue;

    function automatic logic [1:0] mod3(input logic [KW:0] x);
        return 2'(x % (KW+1)'(3));
    endfunction

    function automatic logic [1:0] swap12(input logic [1:0] p);
        return (p == 2'd1) ? 2'd2 : (p == 2'd2) ? 2'd1 : p;
    endfunction

    // Closed-form move k: returns {from, to}. Odd N mirrors pegs B and C so
    // the tower lands on B rather than C.
    function automatic logic [3:0] move_of(input logic [KW:0] k);
        logic [KW:0] km1;
        logic [1:0]  f, t;
        km1 = k - 1'b1;
        f   = mod3(k & km1);
        t   = mod3((k | km1) + 1'b1);
        if (N % 2 == 1) begin
            f = swap12(f);
            t = swap12(t);
        end
        return {f, t};
    endfunction

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_from_next  = PEG_A;
        w_to_next    = PEG_A;
        w_valid_next = 1'b0;
        w_count_next = r_count;
        w_busy_next  = 1'b0;
        w_issue      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_busy_next  = 1'b1;
                    w_issue      = !stall;
                end
            end
            RUN: begin
                w_busy_next = 1'b1;
                w_issue     = !stall;
            end
            default: ; // FINISHED: terminal until reset
        endcase

        if (w_issue) begin
            {w_from_next, w_to_next} = move_of(r_k);
            w_valid_next = 1'b1;
            w_count_next = r_k[KW-1:0];
            w_k_next     = r_k + 1'b1;
            if (r_k == LAST_K) w_state_next = FINISHED;
        end

        // done lags the state by one edge: it rises on the edge after the
        // last move is registered.
        w_done_next = (r_state == FINISHED);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= (KW+1)'(1);
            r_from  <= PEG_A;
            r_to    <= PEG_A;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            r_from  <= w_from_next;
            r_to    <= w_to_next;
            r_valid <= w_valid_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_count <= w_count_next;
        end
    end

    assign from       = r_from;
    assign to         = r_to;
    assign move_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign move_count = r_count;

`ifdef HANOI_SOLVER_CHECK_EN
    localparam int CW = (N < 2) ? 1 : $clog2(N + 1);

    logic [CW-1:0] r_cnt_a, r_cnt_b, r_cnt_c;
    logic [CW-1:0] w_src_cnt;
    logic          r_err;

    always_comb begin
        unique case (w_from_next)
            2'd0:    w_src_cnt = r_cnt_a;
            2'd1:    w_src_cnt = r_cnt_b;
            default: w_src_cnt = r_cnt_c;
        endcase
    end

    // Shadow counters track the move being registered on this edge; a valid
    // move never has from==to, so the source and destination updates never
    // collide on the same counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt_a <= CW'(N);
            r_cnt_b <= '0;
            r_cnt_c <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_valid_next) begin
                unique case (w_from_next)
                    2'd0:    r_cnt_a <= r_cnt_a - 1'b1;
                    2'd1:    r_cnt_b <= r_cnt_b - 1'b1;
                    default: r_cnt_c <= r_cnt_c - 1'b1;
                endcase
                unique case (w_to_next)
                    2'd0:    r_cnt_a <= r_cnt_a + 1'b1;
                    2'd1:    r_cnt_b <= r_cnt_b + 1'b1;
                    default: r_cnt_c <= r_cnt_c + 1'b1;
                endcase
            end
            if ((w_valid_next && (w_src_cnt == '0)) ||
                ((r_state == FINISHED) && (r_cnt_b != CW'(N))))
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_hanoi_solver.sv
module tb_hanoi_solver;

    localparam int NI = 4;
    localparam int NS[NI] = '{3, 4, 1, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[NI], start[NI], stall[NI];
    logic [1:0]  fr[NI], too[NI];
    logic        vld[NI], bsy[NI], dn[NI], er[NI];
    logic [15:0] mc[NI];
    logic [2:0]  mc3;
    logic [3:0]  mc4;
    logic [0:0]  mc1;
    logic [4:0]  mc5;

    hanoi_solver #(.N(3)) u_n3 (
        .clock(clk), .reset(rst[0]), .start(start[0]), .stall(stall[0]),
        .from(fr[0]), .to(too[0]), .move_valid(vld[0]), .busy(bsy[0]),
        .done(dn[0]), .move_count(mc3)
`ifdef HANOI_SOLVER_CHECK_EN
        , .err(er[0])
`endif
    );
    hanoi_solver #(.N(4)) u_n4 (
        .clock(clk), .reset(rst[1]), .start(start[1]), .stall(stall[1]),
        .from(fr[1]), .to(too[1]), .move_valid(vld[1]), .busy(bsy[1]),
        .done(dn[1]), .move_count(mc4)
`ifdef HANOI_SOLVER_CHECK_EN
        , .err(er[1])
`endif
    );
    hanoi_solver #(.N(1)) u_n1 (
        .clock(clk), .reset(rst[2]), .start(start[2]), .stall(stall[2]),
        .from(fr[2]), .to(too[2]), .move_valid(vld[2]), .busy(bsy[2]),
        .done(dn[2]), .move_count(mc1)
`ifdef HANOI_SOLVER_CHECK_EN
        , .err(er[2])
`endif
    );
    hanoi_solver #(.N(5)) u_n5 (
        .clock(clk), .reset(rst[3]), .start(start[3]), .stall(stall[3]),
        .from(fr[3]), .to(too[3]), .move_valid(vld[3]), .busy(bsy[3]),
        .done(dn[3]), .move_count(mc5)
`ifdef HANOI_SOLVER_CHECK_EN
        , .err(er[3])
`endif
    );

    assign mc[0] = 16'(mc3);
    assign mc[1] = 16'(mc4);
    assign mc[2] = 16'(mc1);
    assign mc[3] = 16'(mc5);

    int checks = 0;
    int errors = 0;

    // Reference: recursive optimal solution and a peg-position puzzle model.
    int exp_from[$];
    int exp_to[$];
    int pos[17];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void hanoi(input int n, input int s, input int d, input int a);
        if (n == 0) return;
        hanoi(n - 1, s, a, d);
        exp_from.push_back(s);
        exp_to.push_back(d);
        hanoi(n - 1, a, d, s);
    endfunction

    // Apply an observed move to the puzzle; returns 1 if it was legal.
    function automatic bit apply_move(input int n, input int s, input int d);
        int ts = 99, td = 99;
        if (s == d || s > 2 || d > 2) return 1'b0;
        for (int i = n; i >= 1; i--) begin
            if (pos[i] == s) ts = i;
            if (pos[i] == d) td = i;
        end
        if (ts == 99 || ts > td) return 1'b0;
        pos[ts] = d;
        return 1'b1;
    endfunction

    function automatic bit solved(input int n);
        for (int i = 1; i <= n; i++) if (pos[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int id, input string tag);
        check({tag, "_from"},  32'(fr[id]),  32'd0);
        check({tag, "_to"},    32'(too[id]), 32'd0);
        check({tag, "_valid"}, 32'(vld[id]), 32'd0);
        check({tag, "_busy"},  32'(bsy[id]), 32'd0);
        check({tag, "_done"},  32'(dn[id]),  32'd0);
        check({tag, "_count"}, 32'(mc[id]),  32'd0);
    endtask

    // One solve: mask bit e forces stall before edge e, prob adds random
    // stalls, abort_after>0 asserts reset once that many moves were seen.
    task automatic run(input int id, input int prob, input logic [63:0] mask,
                       input int abort_after);
        int  n     = NS[id];
        int  total = (1 << n) - 1;
        int  idx   = 0;
        int  bound = 4 * (1 << n) + 64;
        bit  sp;
        bit  finished = 1'b0;

        exp_from.delete();
        exp_to.delete();
        hanoi(n, 0, 1, 2);
        for (int i = 1; i <= 16; i++) pos[i] = 0;

        rst[id] = 1'b1; start[id] = 1'b0; stall[id] = 1'b0;
        #1;
        check_idle(id, "reset");
        step();
        rst[id] = 1'b0;

        start[id] = 1'b1;
        for (int e = 0; e < bound && !finished; e++) begin
            sp = ((e < 64) && mask[e]) || ((prob > 0) && ($urandom_range(0, 99) < prob));
            stall[id] = sp;
            step();
            start[id] = 1'b0;
            if (idx < total) begin
                check("busy", 32'(bsy[id]), 32'd1);
                check("done_early", 32'(dn[id]), 32'd0);
                if (sp) begin
                    check("stall_valid", 32'(vld[id]), 32'd0);
                    check("stall_from", 32'(fr[id]), 32'd0);
                    check("stall_to", 32'(too[id]), 32'd0);
                    check("stall_count", 32'(mc[id]), 32'(idx));
                end else begin
                    check("valid", 32'(vld[id]), 32'd1);
                    check("from", 32'(fr[id]), 32'(exp_from[idx]));
                    check("to", 32'(too[id]), 32'(exp_to[idx]));
                    check("count", 32'(mc[id]), 32'(idx + 1));
                    check("legal", 32'(apply_move(n, int'(fr[id]), int'(too[id]))), 32'd1);
                    idx++;
                    if (abort_after > 0 && idx == abort_after) begin
                        rst[id] = 1'b1;
                        stall[id] = 1'b0;
                        #1;
                        check_idle(id, "abort");
                        return;
                    end
                end
            end else begin
                check("done", 32'(dn[id]), 32'd1);
                check("done_busy", 32'(bsy[id]), 32'd0);
                check("done_valid", 32'(vld[id]), 32'd0);
                check("done_from", 32'(fr[id]), 32'd0);
                check("done_to", 32'(too[id]), 32'd0);
                check("done_count", 32'(mc[id]), 32'(total));
                check("puzzle_solved", 32'(solved(n)), 32'd1);
                finished = 1'b1;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $error("FAIL timeout: done not seen within %0d cycles (N=%0d)", bound, n);
            return;
        end

        // Start and stall must be ignored once the tower sits on B.
        for (int i = 0; i < 3; i++) begin
            start[id] = 1'b1;
            stall[id] = 1'($urandom_range(0, 1));
            step();
            check("hold_done", 32'(dn[id]), 32'd1);
            check("hold_valid", 32'(vld[id]), 32'd0);
            check("hold_count", 32'(mc[id]), 32'(total));
        end
        start[id] = 1'b0;
        stall[id] = 1'b0;
`ifdef HANOI_SOLVER_CHECK_EN
        check("err", 32'(er[id]), 32'd0);
        if (id == 0) check("cnt_b", 32'(u_n3.r_cnt_b), 32'd3);
`endif
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; stall[i] = 1'b0;
        end

        run(0, 0, 64'h0, 0);    // N=3 straight run
        run(1, 0, 64'h0, 0);    // N=4 straight run
        run(0, 0, 64'h18, 0);   // N=3, two stalls right after move 3
        run(0, 0, 64'h0, 4);    // N=3, reset after move 4 ...
        run(0, 0, 64'h0, 0);    // ... then a fresh solve
        run(2, 0, 64'h0, 0);    // N=1 single move
        run(0, 0, 64'h1, 0);    // stall together with start
        for (int r = 0; r < 6; r++)
            run(int'($urandom_range(0, NI - 1)), 30, 64'h0, 0);
        run(3, 40, 64'h0, 0);   // N=5 with heavy random stalls

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
